// File: rtl/sap_controller_if.sv
// Bundle between the SAP-1 controller, the ring counter and the datapath.
// The controller (slave side) reads the T-states and the opcode, and
// drives the control word and the status outputs.
interface sap_controller_if #(
  parameter int CNT_W = 8
);
  logic             t1;
  logic             t2;
  logic             t3;
  logic             t4;
  logic             t5;
  logic             t6;
  logic [3:0]       opcode;
  logic [11:0]      con;
  logic             hlt;
  logic             ring_clr_n;
  logic             onehot_err;
  logic [CNT_W-1:0] instr_count;

  modport master (
    output t1, t2, t3, t4, t5, t6, opcode,
    input  con, hlt, ring_clr_n, onehot_err, instr_count
  );

  modport slave (
    input  t1, t2, t3, t4, t5, t6, opcode,
    output con, hlt, ring_clr_n, onehot_err, instr_count
  );
endinterface

// File: rtl/sap_controller.sv
// SAP-1 controller-sequencer: decodes the ring-counter T-state and the
// latched opcode into the 12-bit control word, and keeps the halt latch,
// a sticky one-hot checker and a completed-instruction counter.
// All state changes on the falling edge of clock, like the ring counter.
// Optional build macro SAP_EARLY_RESTART_EN: LDA ends after T5, OUT and
// HLT after T4, by pulling ring_clr_n low during that last state.
module sap_controller #(
  parameter int CNT_W = 8
) (
  input  logic            clock,
  input  logic            clr,
  sap_controller_if.slave bus
);
  // Control word bit order {CP,EP,LM_n,CE_n,LI_n,EI_n,LA_n,EA,SU,EU,LB_n,LO_n}
  localparam logic [11:0] CON_NOP    = 12'h3E3;
  localparam logic [11:0] CON_T1     = 12'h5E3;
  localparam logic [11:0] CON_T2     = 12'hBE3;
  localparam logic [11:0] CON_T3     = 12'h263;
  localparam logic [11:0] CON_MEMADR = 12'h1A3;
  localparam logic [11:0] CON_LDA5   = 12'h2C3;
  localparam logic [11:0] CON_LDB5   = 12'h2E1;
  localparam logic [11:0] CON_ADD6   = 12'h3C7;
  localparam logic [11:0] CON_SUB6   = 12'h3CF;
  localparam logic [11:0] CON_OUT4   = 12'h3F2;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [5:0] ST_T1 = 6'b100000;
  localparam logic [5:0] ST_T2 = 6'b010000;
  localparam logic [5:0] ST_T3 = 6'b001000;
  localparam logic [5:0] ST_T4 = 6'b000100;
  localparam logic [5:0] ST_T5 = 6'b000010;
  localparam logic [5:0] ST_T6 = 6'b000001;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [3:0]       op_reg;
  logic             hlt_reg;
  logic             err_reg;
  logic [CNT_W-1:0] count_reg;

  logic [5:0]  tvec;
  logic        onehot;
  logic        run;
  logic        last_state;
  logic        early_end;
  logic [11:0] con_word;

  assign tvec   = {bus.t1, bus.t2, bus.t3, bus.t4, bus.t5, bus.t6};
  // Exactly one bit set: nonzero and clearing the lowest set bit leaves zero.
  assign onehot = (tvec != 6'b0) && ((tvec & (tvec - 6'd1)) == 6'b0);
  // Normal sequencing only with a clean T-state and no halt or latched error.
  assign run    = clr && onehot && !err_reg && !hlt_reg;

`ifdef SAP_EARLY_RESTART_EN
  logic short_last;
  assign short_last = ((tvec == ST_T4) && ((op_reg == OP_OUT) || (op_reg == OP_HLT)))
                   || ((tvec == ST_T5) && (op_reg == OP_LDA));
  assign early_end  = short_last && !hlt_reg;
  assign last_state = short_last
                   || ((tvec == ST_T6) && (op_reg != OP_LDA)
                       && (op_reg != OP_OUT) && (op_reg != OP_HLT));
`else
  assign early_end  = 1'b0;
  assign last_state = (tvec == ST_T6);
`endif

  // Control word: fetch states are opcode-independent, execute decodes op_reg.
  always_comb begin
    con_word = CON_NOP;
    if (run) begin
      case (tvec)
        ST_T1: con_word = CON_T1;
        ST_T2: con_word = CON_T2;
        ST_T3: con_word = CON_T3;
        ST_T4: begin
          case (op_reg)
            OP_LDA, OP_ADD, OP_SUB: con_word = CON_MEMADR;
            OP_OUT:                 con_word = CON_OUT4;
            default:                con_word = CON_NOP;
          endcase
        end
        ST_T5: begin
          case (op_reg)
            OP_LDA:         con_word = CON_LDA5;
            OP_ADD, OP_SUB: con_word = CON_LDB5;
            default:        con_word = CON_NOP;
          endcase
        end
        ST_T6: begin
          case (op_reg)
            OP_ADD:  con_word = CON_ADD6;
            OP_SUB:  con_word = CON_SUB6;
            default: con_word = CON_NOP;
          endcase
        end
        default: con_word = CON_NOP;
      endcase
    end
  end

  // Opcode latch, halt latch, sticky one-hot error and instruction counter.
  always_ff @(negedge clock) begin
    if (!clr) begin
      op_reg    <= 4'h0;
      hlt_reg   <= 1'b0;
      err_reg   <= 1'b0;
      count_reg <= '0;
    end else begin
      if (bus.t3) begin
        op_reg <= bus.opcode;
      end
      if (!onehot) begin
        err_reg <= 1'b1;
      end
      if (run && (tvec == ST_T4) && (op_reg == OP_HLT)) begin
        hlt_reg <= 1'b1;
      end
      if (run && last_state && (op_reg != OP_HLT)) begin
        count_reg <= count_reg + CNT_ONE;
      end
    end
  end

  assign bus.con         = clr ? con_word : CON_NOP;
  assign bus.ring_clr_n  = clr & ~early_end;
  assign bus.hlt         = hlt_reg;
  assign bus.onehot_err  = err_reg;
  assign bus.instr_count = count_reg;
endmodule

// File: tb/tb_sap_controller.sv
// Bench for sap_controller: directed vector table for the documented
// sequences, then a randomized run against an instruction-level model.
module tb_sap_controller;
`ifdef SAP_EARLY_RESTART_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  localparam logic [11:0] NOP = 12'h3E3;
  localparam logic [5:0] T1 = 6'b100000;
  localparam logic [5:0] T2 = 6'b010000;
  localparam logic [5:0] T3 = 6'b001000;
  localparam logic [5:0] T4 = 6'b000100;
  localparam logic [5:0] T5 = 6'b000010;
  localparam logic [5:0] T6 = 6'b000001;

  logic       clock = 1'b1;
  logic       clr;
  logic [5:0] tv;
  logic [3:0] opc;

  sap_controller_if #(.CNT_W(8)) bus8 ();
  sap_controller_if #(.CNT_W(2)) bus2 ();

  assign {bus8.t1, bus8.t2, bus8.t3, bus8.t4, bus8.t5, bus8.t6} = tv;
  assign {bus2.t1, bus2.t2, bus2.t3, bus2.t4, bus2.t5, bus2.t6} = tv;
  assign bus8.opcode = opc;
  assign bus2.opcode = opc;

  sap_controller #(.CNT_W(8)) dut8 (.clock(clock), .clr(clr), .bus(bus8));
  sap_controller #(.CNT_W(2)) dut2 (.clock(clock), .clr(clr), .bus(bus2));

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  typedef struct {
    bit          clr;
    logic [5:0]  tv;
    logic [3:0]  op;
    logic [11:0] con;
    bit          rcn;
    bit          hlt;
    bit          err;
    int          cnt;
  } vec_t;

  vec_t rows[$];

  task automatic row(input bit c, input logic [5:0] t, input logic [3:0] o,
                     input logic [11:0] cw, input bit r, input bit h,
                     input bit e, input int n);
    vec_t v;
    v.clr = c; v.tv = t; v.op = o; v.con = cw; v.rcn = r;
    v.hlt = h; v.err = e; v.cnt = n;
    rows.push_back(v);
  endtask

  // Reference model state: instruction-level view of the controller.
  bit       m_hlt, m_err;
  int       m_cnt;
  int       m_op;
  int       k;

  function automatic int instr_len(input int op);
    if (!EARLY) return 6;
    if (op == 0) return 5;
    if (op == 14 || op == 15) return 4;
    return 6;
  endfunction

  function automatic logic [11:0] ref_con(input bit c, input bit ok, input int pos, input int op);
    logic [11:0] fetch [3];
    logic [11:0] ex [3];
    fetch = '{12'h5E3, 12'hBE3, 12'h263};
    ex = '{NOP, NOP, NOP};
    if (!c || m_hlt || m_err || !ok) return NOP;
    if (pos <= 3) return fetch[pos-1];
    case (op)
      0:  ex = '{12'h1A3, 12'h2C3, NOP};
      1:  ex = '{12'h1A3, 12'h2E1, 12'h3C7};
      2:  ex = '{12'h1A3, 12'h2E1, 12'h3CF};
      14: ex = '{12'h3F2, NOP, NOP};
      default: ex = '{NOP, NOP, NOP};
    endcase
    return ex[pos-4];
  endfunction

  initial begin
    // Directed sequences
    row(0, T1, 4'h0, NOP,     0, 0, 0, 0);
    // LDA, IR changes after T3 must not matter
    row(1, T1, 4'h0, 12'h5E3, 1, 0, 0, 0);
    row(1, T2, 4'h0, 12'hBE3, 1, 0, 0, 0);
    row(1, T3, 4'h0, 12'h263, 1, 0, 0, 0);
    row(1, T4, 4'h5, 12'h1A3, 1, 0, 0, 0);
    row(1, T5, 4'h5, 12'h2C3, !EARLY, 0, 0, 0);
`ifndef SAP_EARLY_RESTART_EN
    row(1, T6, 4'h5, NOP,     1, 0, 0, 0);
`endif
    // SUB with IR switched to ADD during T5
    row(1, T1, 4'h2, 12'h5E3, 1, 0, 0, 1);
    row(1, T2, 4'h2, 12'hBE3, 1, 0, 0, 1);
    row(1, T3, 4'h2, 12'h263, 1, 0, 0, 1);
    row(1, T4, 4'h2, 12'h1A3, 1, 0, 0, 1);
    row(1, T5, 4'h1, 12'h2E1, 1, 0, 0, 1);
    row(1, T6, 4'h1, 12'h3CF, 1, 0, 0, 1);
    // OUT
    row(1, T1, 4'hE, 12'h5E3, 1, 0, 0, 2);
    row(1, T2, 4'hE, 12'hBE3, 1, 0, 0, 2);
    row(1, T3, 4'hE, 12'h263, 1, 0, 0, 2);
    row(1, T4, 4'hE, 12'h3F2, !EARLY, 0, 0, 2);
`ifndef SAP_EARLY_RESTART_EN
    row(1, T5, 4'hE, NOP,     1, 0, 0, 2);
    row(1, T6, 4'hE, NOP,     1, 0, 0, 2);
`endif
    // HLT
    row(1, T1, 4'hF, 12'h5E3, 1, 0, 0, 3);
    row(1, T2, 4'hF, 12'hBE3, 1, 0, 0, 3);
    row(1, T3, 4'hF, 12'h263, 1, 0, 0, 3);
    row(1, T4, 4'hF, NOP,     !EARLY, 0, 0, 3);
`ifdef SAP_EARLY_RESTART_EN
    row(1, T1, 4'hF, NOP,     1, 1, 0, 3);
    row(1, T2, 4'hF, NOP,     1, 1, 0, 3);
`else
    row(1, T5, 4'hF, NOP,     1, 1, 0, 3);
    row(1, T6, 4'hF, NOP,     1, 1, 0, 3);
`endif
    // Reset clears halt and count
    row(0, T1, 4'h0, NOP,     0, 1, 0, 3);
    row(1, T1, 4'h0, 12'h5E3, 1, 0, 0, 0);
    // One-hot violation, sticky until reset
    row(1, T2, 4'h0, 12'hBE3, 1, 0, 0, 0);
    row(1, 6'b011000, 4'h7, NOP, 1, 0, 0, 0);
    row(1, T4, 4'h7, NOP,     1, 0, 1, 0);
    row(0, T5, 4'h7, NOP,     0, 0, 1, 0);
    row(1, T1, 4'h1, 12'h5E3, 1, 0, 0, 0);
    // Full ADD, then an ADD aborted by reset in T5
    row(1, T2, 4'h1, 12'hBE3, 1, 0, 0, 0);
    row(1, T3, 4'h1, 12'h263, 1, 0, 0, 0);
    row(1, T4, 4'h1, 12'h1A3, 1, 0, 0, 0);
    row(1, T5, 4'h1, 12'h2E1, 1, 0, 0, 0);
    row(1, T6, 4'h1, 12'h3C7, 1, 0, 0, 0);
    row(1, T1, 4'h1, 12'h5E3, 1, 0, 0, 1);
    row(1, T2, 4'h1, 12'hBE3, 1, 0, 0, 1);
    row(1, T3, 4'h1, 12'h263, 1, 0, 0, 1);
    row(1, T4, 4'h1, 12'h1A3, 1, 0, 0, 1);
    row(0, T5, 4'h1, NOP,     0, 0, 0, 1);
    row(1, T1, 4'h1, 12'h5E3, 1, 0, 0, 0);

    clr = 1'b0; tv = T1; opc = 4'h0;
    @(negedge clock); #1;

    foreach (rows[i]) begin
      clr = rows[i].clr; tv = rows[i].tv; opc = rows[i].op;
      @(posedge clock); #1;
      check($sformatf("vec%0d con", i), bus8.con, rows[i].con);
      check($sformatf("vec%0d ring_clr_n", i), bus8.ring_clr_n, rows[i].rcn);
      check($sformatf("vec%0d hlt", i), bus8.hlt, rows[i].hlt);
      check($sformatf("vec%0d onehot_err", i), bus8.onehot_err, rows[i].err);
      check($sformatf("vec%0d count", i), bus8.instr_count, rows[i].cnt % 256);
      check($sformatf("vec%0d count_w2", i), bus2.instr_count, rows[i].cnt % 4);
      @(negedge clock); #1;
    end

    // Randomized run with a behavioural ring counter and model
    m_hlt = 0; m_err = 0; m_cnt = 0; m_op = 0; k = 1;
    for (int i = 0; i < 2000; i++) begin
      bit c, ok, early, rcn_exp, hlt_n, err_n;
      int r, len;
      logic [11:0] con_exp;
      logic [5:0] v;
      c = !(i == 0 || $urandom_range(0, 39) == 0 || (m_err && $urandom_range(0, 3) == 0));
      r = $urandom_range(0, 7);
      case (r)
        0: opc = 4'h0;
        1: opc = 4'h1;
        2: opc = 4'h2;
        3: opc = 4'hE;
        4: opc = ($urandom_range(0, 2) == 0) ? 4'hF : 4'h1;
        default: opc = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 99) == 0) begin
        v = 6'($urandom_range(0, 63));
        while ($countones(v) == 1) v = 6'($urandom_range(0, 63));
      end else begin
        v = T1 >> (k - 1);
      end
      clr = c; tv = v;
      ok = ($countones(v) == 1);
      len = instr_len(m_op);
      con_exp = ref_con(c, ok, k, m_op);
      early = ok && !m_hlt && (k == len) && (len < 6);
      rcn_exp = c && !early;

      @(posedge clock); #1;
      check("rnd con", bus8.con, con_exp);
      check("rnd ring_clr_n", bus8.ring_clr_n, rcn_exp);
      check("rnd hlt", bus8.hlt, m_hlt);
      check("rnd onehot_err", bus8.onehot_err, m_err);
      check("rnd count", bus8.instr_count, m_cnt % 256);
      check("rnd count_w2", bus2.instr_count, m_cnt % 4);
      @(negedge clock); #1;

      if (!c) begin
        m_hlt = 0; m_err = 0; m_cnt = 0; m_op = 0;
      end else begin
        hlt_n = m_hlt; err_n = m_err;
        if (!ok) err_n = 1;
        if (ok && !m_err && !m_hlt) begin
          if (k == 4 && m_op == 15) hlt_n = 1;
          if (k == len && m_op != 15) m_cnt++;
        end
        if (v[3]) m_op = int'(opc);
        m_hlt = hlt_n; m_err = err_n;
      end
      k = rcn_exp ? (k % 6) + 1 : 1;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sap_controller.md
Name: sap_controller

Overview:
Controller-sequencer for the SAP-1 datapath. It consumes the one-hot T-state outputs t1..t6 of the ring counter and the instruction-register opcode, and produces the 12-bit control word that drives the datapath. It drives the ring counter's clear input back (ring_clr_n) so that short instructions end early. It also holds the halt latch, a sticky one-hot checker and a completed-instruction counter. All sequential state updates on the falling edge of clock, the same edge the ring counter uses.

Parameters:
CNT_W, 8, width of instr_count; wraps modulo 2^CNT_W

Ports:
clock  input  1  system clock; all state updates on negedge
clr  input  1  reset, synchronous, active-low, sampled on negedge clock
t1..t6  input  1 each  one-hot T-state from the ring counter
opcode  input  4  instruction register upper nibble
con  output  12  control word {CP,EP,LM_n,CE_n,LI_n,EI_n,LA_n,EA,SU,EU,LB_n,LO_n}; combinational
hlt  output  1  halt flag (registered); drives external clock gating
ring_clr_n  output  1  clear to the ring counter; combinational
onehot_err  output  1  sticky T-state violation flag (registered)
instr_count  output  CNT_W  count of completed instructions (registered)

Behaviour:
- Reset: clock is one clock; reset is synchronous and active-low (clr). On any negedge with clr=0: hlt=0, onehot_err=0, instr_count=0, op_r=4'h0.
- While clr=0: con=NOP (12'h3E3) and ring_clr_n=0, combinationally, so the ring counter restarts at T1. Reset mid-instruction abandons that instruction and does not count it.
- NOP word 12'h3E3: all active-low bits 1, all active-high bits 0.
- op_r: internal 4-bit register, loaded from opcode at the negedge where t3=1. T4..T6 decode uses op_r only, so later IR changes are ignored.
- Fetch, independent of opcode:
  - T1 = 12'h5E3 (EP, LM_n)
  - T2 = 12'hBE3 (CP)
  - T3 = 12'h263 (CE_n, LI_n)
- Execute, decoded from op_r:
  - LDA 0000: T4 12'h1A3 (EI_n, LM_n); T5 12'h2C3 (CE_n, LA_n); T6 NOP.
  - ADD 0001: T4 12'h1A3; T5 12'h2E1 (CE_n, LB_n); T6 12'h3C7 (LA_n, EU).
  - SUB 0010: same as ADD except T6 12'h3CF (adds SU).
  - OUT 1110: T4 12'h3F2 (EA, LO_n); T5, T6 NOP.
  - HLT 1111: T4..T6 NOP. At the negedge ending T4, hlt is set to 1.
  - Opcodes 0011..1101: NOP in T4..T6, always a full 6 states, counted as completed.
- Halt: once hlt=1, con is forced to NOP and instr_count is frozen. Only clr=0 clears hlt. The HLT instruction itself is not counted.
- One-hot check: at each negedge with clr=1, if {t1..t6} is not exactly one-hot, onehot_err is set and stays set until clr=0. While onehot_err=1 (and in any cycle where the vector is not one-hot), con=NOP and instr_count is frozen.
- Last state of an instruction:
  - Without early restart: T6 for every opcode.
  - With early restart: LDA T5, OUT T4, HLT T4, all others T6.
- Counting: instr_count increments by 1 at the negedge ending the last state, when clr=1, hlt=0 and onehot_err=0. It wraps from 2^CNT_W-1 to 0.
- ring_clr_n = clr AND NOT(early_end), where early_end is 1 only during a shortened last state (T4 or T5) with hlt=0. The ring counter then sees clear at that negedge and goes to T1.

Optional Feature:
SAP_EARLY_RESTART_EN
- Defined: LDA takes 5 T-states, OUT 4, HLT 4 (early_end as above); ADD, SUB and undefined opcodes take 6.
- Undefined: early_end is tied to 0, ring_clr_n = clr, and every instruction takes 6 T-states.

Test Plan:
- Reset, then LDA (opcode 0000) through T1..T6 -> con sequence 5E3, BE3, 263, 1A3, 2C3, 3E3; instr_count 0 -> 1 at the end of T6 (feature off), or at the end of T5 with ring_clr_n=0 during T5 (feature on).
- SUB with opcode changed to 0001 during T5 -> T6 still 12'h3CF, because op_r was latched at T3.
- OUT followed by HLT -> OUT T4 = 12'h3F2; hlt=1 after HLT T4; con=3E3 afterwards; instr_count stays at 1.
- Drive t2 and t3 high together for one cycle -> con=3E3 that cycle; onehot_err=1 and held; clr=0 clears it.
- clr=0 during ADD T5 -> con=3E3, ring_clr_n=0; next negedge instr_count=0, hlt=0.
- CNT_W=2, run 4 ADDs from 0 -> instr_count 1, 2, 3, 0.
